// File: rtl/button_event_unit.sv
// Push-button front end: synchroniser, debouncer and register-20 event status word.
// Optional held-button auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event_unit #(
    parameter int unsigned DB_CYCLES     = 1000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        button_raw,
    input  logic        ctrl_clear20,
    output logic [31:0] r20,
    output logic        button_signal_reg
);

    localparam int unsigned DBW = $clog2(DB_CYCLES);

    if (DB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("button_event_unit: DB_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic           s1, s2, db;
    logic [DBW-1:0] db_cnt;

    // Two-flop synchroniser feeding the debouncer
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db     <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= button_raw;
            s2 <= s1;
            if (s2 == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
                db     <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Registered status fields; lvl is the copy of db already visible in r20
    logic       flag, lvl;
    logic [7:0] cnt;
    logic       flag_nx, lvl_nx;
    logic [7:0] cnt_nx;
    logic       press, fire, changed;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES);

    logic [RW-1:0] rep_cnt;
    logic          hold;

    // Counting starts the cycle after the press event lands in r20
    assign hold = db & lvl;
    assign fire = hold && (rep_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (ctrl_reset || !hold) begin
            rep_cnt <= '0;
        end else if (fire) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign fire = 1'b0;
`endif

    assign press = (db & ~lvl) | fire;

    always_comb begin
        flag_nx = flag;
        lvl_nx  = db;
        cnt_nx  = cnt;
        if (ctrl_clear20) flag_nx = 1'b0;
        // A press on the same edge as a clear wins
        if (press) begin
            flag_nx = 1'b1;
            cnt_nx  = cnt + 8'd1;
        end
        changed = (flag_nx != flag) || (lvl_nx != lvl) || (cnt_nx != cnt);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            flag              <= 1'b0;
            lvl               <= 1'b0;
            cnt               <= 8'd0;
            button_signal_reg <= 1'b0;
        end else begin
            flag              <= flag_nx;
            lvl               <= lvl_nx;
            cnt               <= cnt_nx;
            button_signal_reg <= changed;
        end
    end

    assign r20 = {16'h0000, cnt, 6'b000000, lvl, flag};

endmodule
